// File: rtl/edge_trigger_bank_if.sv
// Channel bus for edge_trigger_bank: raw inputs and mode/clear controls in,
// stretched pulses, sticky flags and event count out.
interface edge_trigger_bank_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in;
    logic [1:0]       mode;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic             any;
    logic [WIDTH-1:0] sticky;
    logic [CNT_W-1:0] evt_cnt;

    modport master (output in, mode, clr, input out, any, sticky, evt_cnt);
    modport slave  (input in, mode, clr, output out, any, sticky, evt_cnt);
endinterface

// File: rtl/edge_trigger_bank.sv
// Multi-channel synchronised edge trigger with mode gating, pulse stretch,
// sticky flags and a saturating event counter.
module edge_trigger_bank_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_in,
    input  logic [1:0] i_mode,
    output logic       o_hit,
    output logic       o_out,
    output logic       o_out_nxt
);
    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        o_hit = 1'b0;
        unique case (i_mode)
            2'b00: o_hit = w_s ^ r_prev;
            2'b01: o_hit = w_s & ~r_prev;
            2'b10: o_hit = ~w_s & r_prev;
            2'b11: o_hit = 1'b0;
        endcase
    end

    // A hit always reloads the full length, so a retrigger extends the pulse.
    always_comb begin
        w_cnt_nxt = '0;
        if (o_hit)
            w_cnt_nxt = CW'(PULSE_LEN);
        else if (r_cnt != '0)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    // Reset preloads the chain with the live input so a held level is not an edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync <= {SYNC_STAGES{i_in}};
            r_prev <= i_in;
            r_cnt  <= '0;
        end else begin
            r_sync[0] <= i_in;
            for (int k = 1; k < SYNC_STAGES; k++)
                r_sync[k] <= r_sync[k-1];
            r_prev <= w_s;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_out     = (r_cnt != '0);
    assign o_out_nxt = (w_cnt_nxt != '0);
endmodule

module edge_trigger_bank #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_W       = 16
) (
    input logic                clk,
    input logic                rstn,
    edge_trigger_bank_if.slave bus
);
    localparam int SW = CNT_W + $clog2(WIDTH + 1);

    logic [WIDTH-1:0] w_hit;
    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [SW-1:0]    w_sum;
    logic             w_sat;
    logic             r_any;
    logic [WIDTH-1:0] r_sticky;
    logic [CNT_W-1:0] r_evt;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_lane
            edge_trigger_bank_lane #(
                .SYNC_STAGES(SYNC_STAGES),
                .PULSE_LEN  (PULSE_LEN)
            ) u_lane (
                .clk      (clk),
                .rstn     (rstn),
                .i_in     (bus.in[g]),
                .i_mode   (bus.mode),
                .o_hit    (w_hit[g]),
                .o_out    (w_out[g]),
                .o_out_nxt(w_out_nxt[g])
            );
        end
    endgenerate

    // Extra headroom bits catch overflow of the sum before saturation.
    always_comb begin
        w_sum = bus.clr ? '0 : SW'(r_evt);
        for (int i = 0; i < WIDTH; i++)
            w_sum = w_sum + SW'(w_hit[i]);
        w_sat = |w_sum[SW-1:CNT_W];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_any    <= 1'b0;
            r_sticky <= '0;
            r_evt    <= '0;
        end else begin
            r_any    <= |w_out_nxt;
            r_sticky <= (bus.clr ? '0 : r_sticky) | w_hit;
            r_evt    <= w_sat ? '1 : w_sum[CNT_W-1:0];
        end
    end

    assign bus.out     = w_out;
    assign bus.any     = r_any;
    assign bus.sticky  = r_sticky;
    assign bus.evt_cnt = r_evt;
endmodule

// File: tb/tb_edge_trigger_bank.sv
// Bench for edge_trigger_bank: default instance A driven from a vector table,
// stretch/saturation instance B (PULSE_LEN=4, CNT_W=3) driven by hand sequences.
module tb_edge_trigger_bank;
    logic clk = 1'b0;
    logic rstn_a, rstn_b;
    int   n_chk = 0;
    int   n_err = 0;

    always #10 clk = ~clk;

    edge_trigger_bank_if #(.WIDTH(4), .CNT_W(16)) bus_a ();
    edge_trigger_bank_if #(.WIDTH(4), .CNT_W(3))  bus_b ();

    edge_trigger_bank #(.WIDTH(4), .SYNC_STAGES(2), .PULSE_LEN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rstn(rstn_a), .bus(bus_a));
    edge_trigger_bank #(.WIDTH(4), .SYNC_STAGES(2), .PULSE_LEN(4), .CNT_W(3)) dut_b (
        .clk(clk), .rstn(rstn_b), .bus(bus_b));

    typedef struct {
        logic [3:0]  in;
        logic [1:0]  mode;
        logic [3:0]  out;
        logic        any;
        logic [3:0]  sticky;
        logic [15:0] evt;
    } vec_t;

    vec_t tbl[34];
    vec_t sb[$];
    bit   sb_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input int k, input vec_t e);
        chk($sformatf("row%0d.out", k),    32'(bus_a.out),     32'(e.out));
        chk($sformatf("row%0d.any", k),    32'(bus_a.any),     32'(e.any));
        chk($sformatf("row%0d.sticky", k), 32'(bus_a.sticky),  32'(e.sticky));
        chk($sformatf("row%0d.evt", k),    32'(bus_a.evt_cnt), 32'(e.evt));
    endtask

    // Each row: inputs driven at a negedge; expected outputs are those seen
    // three negedges later (after capture edge + 2).
    initial begin
        tbl[0]  = '{4'hF, 2'b11, 4'h0, 1'b0, 4'h0, 16'd0};
        tbl[1]  = '{4'h0, 2'b11, 4'h0, 1'b0, 4'h0, 16'd0};
        tbl[2]  = '{4'h0, 2'b11, 4'h0, 1'b0, 4'h0, 16'd0};
        tbl[3]  = '{4'h0, 2'b11, 4'h0, 1'b0, 4'h0, 16'd0};
        tbl[4]  = '{4'h1, 2'b00, 4'h1, 1'b1, 4'h1, 16'd1};
        tbl[5]  = '{4'h1, 2'b00, 4'h0, 1'b0, 4'h1, 16'd1};
        tbl[6]  = '{4'h1, 2'b00, 4'h0, 1'b0, 4'h1, 16'd1};
        tbl[7]  = '{4'h1, 2'b00, 4'h0, 1'b0, 4'h1, 16'd1};
        tbl[8]  = '{4'h1, 2'b00, 4'h0, 1'b0, 4'h1, 16'd1};
        tbl[9]  = '{4'h0, 2'b00, 4'h1, 1'b1, 4'h1, 16'd2};
        tbl[10] = '{4'h0, 2'b00, 4'h0, 1'b0, 4'h1, 16'd2};
        tbl[11] = '{4'h0, 2'b00, 4'h0, 1'b0, 4'h1, 16'd2};
        tbl[12] = '{4'h0, 2'b01, 4'h0, 1'b0, 4'h1, 16'd2};
        tbl[13] = '{4'h2, 2'b01, 4'h2, 1'b1, 4'h3, 16'd3};
        tbl[14] = '{4'h2, 2'b01, 4'h0, 1'b0, 4'h3, 16'd3};
        tbl[15] = '{4'h0, 2'b01, 4'h0, 1'b0, 4'h3, 16'd3};
        tbl[16] = '{4'h0, 2'b01, 4'h0, 1'b0, 4'h3, 16'd3};
        tbl[17] = '{4'h0, 2'b01, 4'h0, 1'b0, 4'h3, 16'd3};
        tbl[18] = '{4'h0, 2'b10, 4'h0, 1'b0, 4'h3, 16'd3};
        tbl[19] = '{4'h2, 2'b10, 4'h0, 1'b0, 4'h3, 16'd3};
        tbl[20] = '{4'h2, 2'b10, 4'h0, 1'b0, 4'h3, 16'd3};
        tbl[21] = '{4'h0, 2'b10, 4'h2, 1'b1, 4'h3, 16'd4};
        tbl[22] = '{4'h0, 2'b10, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[23] = '{4'h0, 2'b10, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[24] = '{4'h0, 2'b11, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[25] = '{4'h2, 2'b11, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[26] = '{4'h2, 2'b11, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[27] = '{4'h0, 2'b11, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[28] = '{4'h0, 2'b11, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[29] = '{4'h0, 2'b11, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[30] = '{4'h0, 2'b00, 4'h0, 1'b0, 4'h3, 16'd4};
        tbl[31] = '{4'hF, 2'b00, 4'hF, 1'b1, 4'hF, 16'd8};
        tbl[32] = '{4'hF, 2'b00, 4'h0, 1'b0, 4'hF, 16'd8};
        tbl[33] = '{4'hF, 2'b00, 4'h0, 1'b0, 4'hF, 16'd8};
    end

    initial begin
        int k_pop;
        int run;
        vec_t e;
        rstn_a = 1'b0; rstn_b = 1'b0;
        bus_a.in = 4'hF; bus_a.mode = 2'b00; bus_a.clr = 1'b0;
        bus_b.in = 4'h0; bus_b.mode = 2'b00; bus_b.clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a.out", 32'(bus_a.out), 32'h0);
        chk("rst_b.evt", 32'(bus_b.evt_cnt), 32'h0);
        rstn_a = 1'b1; rstn_b = 1'b1;

        // Level held high through reset release must not look like an edge.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", c),
                32'({bus_a.out, bus_a.any, bus_a.sticky, bus_a.evt_cnt}), 32'h0);
        end

        k_pop = 0;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (sb.size() == 3) begin
                e = sb.pop_front();
                chk_row(k_pop, e);
                k_pop++;
            end
            bus_a.in   = tbl[k].in;
            bus_a.mode = tbl[k].mode;
            sb.push_back(tbl[k]);
        end
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            chk_row(k_pop, e);
            k_pop++;
        end

        // clr lands in the same cycle as a detected fall on channel 2.
        bus_a.in = 4'hB;
        @(negedge clk);
        @(negedge clk);
        chk("clr.pre_evt", 32'(bus_a.evt_cnt), 32'd8);
        bus_a.clr = 1'b1;
        @(negedge clk);
        bus_a.clr = 1'b0;
        chk("clr.sticky", 32'(bus_a.sticky), 32'h4);
        chk("clr.evt", 32'(bus_a.evt_cnt), 32'd1);
        chk("clr.out", 32'(bus_a.out), 32'h4);
        @(negedge clk);
        chk("clr.out_end", 32'(bus_a.out), 32'h0);
        chk("clr.sticky_hold", 32'(bus_a.sticky), 32'h4);

        // Stretch and retrigger on B, channel 3: rise then fall two cycles later.
        @(negedge clk);
        for (int j = 0; j < 10; j++) sb_b.push_back(j >= 2 && j <= 7);
        bus_b.in = 4'h8;
        run = 0;
        for (int j = 0; j < 10; j++) begin
            bit ex;
            @(negedge clk);
            if (j == 1) bus_b.in = 4'h0;
            ex = sb_b.pop_front();
            chk($sformatf("stretch%0d.out3", j), 32'(bus_b.out[3]), 32'(ex));
            chk($sformatf("stretch%0d.any", j), 32'(bus_b.any), 32'(ex));
            if (bus_b.out[3]) run++;
        end
        chk("stretch.len", 32'(run), 32'd6);
        chk("stretch.evt", 32'(bus_b.evt_cnt), 32'd2);

        // Saturation: clear, then nine single-cycle toggles of channel 0.
        bus_b.clr = 1'b1;
        @(negedge clk);
        bus_b.clr = 1'b0;
        chk("sat.cleared", 32'(bus_b.evt_cnt), 32'd0);
        for (int j = 0; j < 9; j++) begin
            bus_b.in[0] = ~bus_b.in[0];
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("sat.evt", 32'(bus_b.evt_cnt), 32'd7);
        chk("sat.sticky", 32'(bus_b.sticky), 32'h1);
        repeat (4) @(negedge clk);
        chk("sat.idle_out", 32'(bus_b.out), 32'h0);
        chk("sat.hold", 32'(bus_b.evt_cnt), 32'd7);

        // Reset one cycle into a pulse truncates it and clears the counter.
        bus_b.in[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid.pulse", 32'(bus_b.out), 32'h1);
        rstn_b = 1'b0;
        @(negedge clk);
        chk("rstmid.out", 32'(bus_b.out), 32'h0);
        chk("rstmid.evt", 32'(bus_b.evt_cnt), 32'd0);
        chk("rstmid.sticky", 32'(bus_b.sticky), 32'h0);
        chk("rstmid.any", 32'(bus_b.any), 32'h0);
        rstn_b = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid.quiet", 32'({bus_b.out, bus_b.evt_cnt}), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
